// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, deframes 11-bit frames
// and turns arrow-key / S-key make codes into single-cycle pulses.
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 12500
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       start_req,
  output logic [7:0] scan_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]       scan_byte_q;
  logic             byte_valid_q, frame_err_q;
  logic             ext_q, brk_q;
  logic [3:0]       direction_q;
  logic             start_req_q;
  logic             fall, timeout;

  // Two-flop synchronizers; idle-high lines reset to 1 so release never looks like an edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LIMIT);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (fall || state_q == IDLE) to_cnt_d = '0;
    else if (to_cnt_q != TO_LIMIT) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  // Frame FSM; an edge in the same cycle as the limit keeps the frame alive
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      scan_byte_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (timeout) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else if (fall) begin
        unique case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            if (!dat_s2_q) state_q <= DATA;
          end
          DATA: begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= dat_s2_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (dat_s2_q && (^{shift_q, parity_q})) begin
              scan_byte_q  <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Scan-code decoder: E0/F0 prefixes arm flags, the next ordinary byte consumes them
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      direction_q <= '0;
      start_req_q <= 1'b0;
    end else begin
      direction_q <= '0;
      start_req_q <= 1'b0;
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (scan_byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (scan_byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          if (!brk_q) begin
            if (ext_q) begin
              case (scan_byte_q)
                8'h75:   direction_q <= 4'b1000;
                8'h72:   direction_q <= 4'b0100;
                8'h6B:   direction_q <= 4'b0010;
                8'h74:   direction_q <= 4'b0001;
                default: direction_q <= 4'b0000;
              endcase
            end else if (scan_byte_q == 8'h1B) begin
              start_req_q <= 1'b1;
            end
          end
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign direction  = direction_q;
  assign start_req  = start_req_q;
  assign scan_byte  = scan_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_direction_decoder.md
PS2_DIRECTION_DECODER -- requirements
Module: ps2_direction_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 12500, the maximum clock cycles allowed between PS/2 clock falling edges inside one frame (250 us at 50 MHz).
REQ-002 SHALL have port clock, input, 1, system clock (CLOCK_50 domain); one clock for all logic.
REQ-003 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port ps2_clk, input, 1, keyboard clock, asynchronous to clock.
REQ-005 SHALL have port ps2_dat, input, 1, keyboard data, asynchronous to clock.
REQ-006 SHALL have port direction, output, 4, one-cycle make pulse: [3]=up, [2]=down, [1]=left, [0]=right; at most one bit high per cycle.
REQ-007 SHALL have port start_req, output, 1, one-cycle pulse on S key make.
REQ-008 SHALL have port scan_byte, output, 8, last correctly received byte.
REQ-009 SHALL have port byte_valid, output, 1, one-cycle pulse when scan_byte updates.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchronizer before any use.
REQ-012 SHALL detect a falling edge when the synchronized ps2_clk is 0 and its previous registered value is 1; all frame bits are sampled from synchronized ps2_dat in that cycle.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no error (glitch reject).
REQ-015 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture bit -> STOP; odd parity required (data bits + parity bit have odd count of ones).
REQ-017 STOP: on edge -> IDLE; if stop bit 1 and parity OK, load scan_byte and pulse byte_valid the next cycle; else pulse frame_err the next cycle, scan_byte unchanged.
REQ-018 Timeout counter resets on every edge and in IDLE; if it reaches TIMEOUT_CYCLES outside IDLE -> IDLE, frame_err pulse, partial byte discarded.
REQ-019 Edge and timeout in the same cycle: edge wins, no timeout.
REQ-020 Byte decoder holds flags ext and brk: byte E0 sets ext; F0 sets brk; no output for either.
REQ-021 Any other byte: if brk=0, decode; then clear ext and brk in the same cycle.
REQ-022 Decode with ext=1: 75 -> up, 72 -> down, 6B -> left, 74 -> right; all others no output.
REQ-023 Decode with ext=0: 1B -> start_req; all others no output.
REQ-024 direction and start_req SHALL pulse exactly one cycle, the cycle after byte_valid.
REQ-025 Break sequences (F0 xx or E0 F0 xx) SHALL produce no pulses.
REQ-026 Typematic repeats SHALL produce one pulse per received make code.
REQ-027 frame_err SHALL clear ext and brk.
REQ-028 Latency: stop-bit edge detect to byte_valid 1 cycle, to direction/start_req 2 cycles.

Reset
REQ-029 While resetn=0: FSM IDLE, counters 0, ext=brk=0, synchronizers 1, scan_byte 00, direction 0000, start_req 0, byte_valid 0, frame_err 0.
REQ-030 Reset assertion mid-frame SHALL abort the frame with no pulses; first frame after release decodes normally.

Verification
REQ-031 Frame E0 then frame 75, valid parity -> byte_valid twice, scan_byte 75, direction=1000 for exactly 1 cycle.
REQ-032 Frames E0, F0, 6B -> no direction pulse; next frame 6B -> no pulse (ext cleared); next E0, 6B -> direction=0010 one cycle.
REQ-033 Frame 1B with even parity -> frame_err one cycle, no byte_valid, no start_req, scan_byte holds prior value; then valid 1B -> start_req one cycle.
REQ-034 Send start bit + 4 data bits, then stall ps2_clk high for TIMEOUT_CYCLES -> frame_err one cycle, FSM IDLE; next valid frame 74 after E0 -> direction=0001.
REQ-035 Frame with stop bit 0 -> frame_err; single ps2_clk falling edge with ps2_dat 1 in IDLE -> no error, stays IDLE.
REQ-036 resetn low during DATA of frame 72 -> all outputs 0, no pulses after release; subsequent E0, 72 -> direction=0100.
